data_mem_ctrl: RTL and testbench

- Memory-side responder for the register file's load/store interface.
- Accepts one load or store request per transaction from decode/register file: address, store data and destination register tag.
- Stores write a 256x8 data memory. Loads return `loadData` with a one-cycle `loadEn` pulse plus the destination tag after a fixed latency.
- Asserts `busy` so the program counter stalls while a load is in flight.

---
 rtl/instr_pack.sv | 23 ++
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem_ctrl.sv | 103 ++++++++++
 tb/tb_data_mem_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pack.sv
// Shared types for the load/store path: register codes, data-memory FSM
// states and data-memory sizing.
package instr_pack;

  // Architectural register codes carried as load destination tags.
  typedef enum logic [3:0] {
    rega, regb, regc, regd, rege, regf, regg, regh,
    regx, regy, regz, regsp, regpc, regir, regfl, regnone
  } register;

  // Data-memory controller states.
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DEPTH  = 2 ** DMEM_ADDR_W;
  localparam int DMEM_CNT_W  = 3;

  // Value loaded into the latency counter when a load is accepted.
  function automatic logic [DMEM_CNT_W-1:0] lat_preload(input int lat);
    return DMEM_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W data memory: synchronous write, combinational read,
// contents survive reset.
module data_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-side responder for the register file's load/store interface.
//
// Handshake: upstream may present ld_req or st_req (never both) on any
// cycle where busy is 0; the request is taken on that posedge. A store
// completes on the same edge. A load raises busy on its accepting edge and
// returns a one-cycle loadEn pulse LD_LAT edges later, on the same edge that
// drops busy; loadData/load_tag then hold until the next response. Any
// request made while busy, or both requests together, is dropped and sets
// the sticky req_err flag.
//
// A load moves IDLE -> (WAIT) -> RESP -> IDLE. RESP is the last busy cycle;
// the edge leaving it drives loadEn, so the loadEn cycle is already IDLE and
// accepts a new request, giving LD_LAT+1 cycles per back-to-back load.
module data_mem_ctrl
  import instr_pack::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = 8,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int LD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storData,
  input  logic [3:0]        dst_tag,
  output logic              loadEn,
  output logic [DATA_W-1:0] loadData,
  output logic [3:0]        load_tag,
  output logic              busy,
  output logic              req_err
);

  mem_state_t            state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]     cap_addr;
  register               cap_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en;

  // Stores are only honoured from IDLE and only when not paired with a load.
  assign wr_en = (state == MEM_IDLE) && st_req && !ld_req;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (storData),
    .rd_addr (cap_addr),
    .rd_data (rd_data)
  );

  // Load FSM, latency counter, request captures and protocol-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_tag  <= rega;
      loadEn   <= 1'b0;
      loadData <= '0;
      load_tag <= '0;
      busy     <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      loadEn <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (ld_req && st_req) begin
            req_err <= 1'b1;
          end else if (ld_req) begin
            cap_addr <= addr;
            cap_tag  <= register'(dst_tag);
            cnt      <= lat_preload(LD_LAT);
            busy     <= 1'b1;
            state    <= (LD_LAT == 1) ? MEM_RESP : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (ld_req || st_req) req_err <= 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == DMEM_CNT_W'(1)) state <= MEM_RESP;
        end
        MEM_RESP: begin
          if (ld_req || st_req) req_err <= 1'b1;
          loadEn   <= 1'b1;
          loadData <= rd_data;
          load_tag <= cap_tag;
          busy     <= 1'b0;
          state    <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the memory.
module tb_data_mem_ctrl;
  import instr_pack::*;

  localparam int LD_LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_req, st_req;
  logic [7:0] addr, storData;
  logic [3:0] dst_tag;
  logic       loadEn;
  logic [7:0] loadData;
  logic [3:0] load_tag;
  logic       busy, req_err;

  int tests = 0;
  int fails = 0;

  // Reference model: memory image, one pending load with its due edge.
  logic [7:0] m_mem [256];
  int         cyc;
  bit         m_pend;
  int         m_due;
  logic [7:0] m_addr;
  logic [3:0] m_tag;
  bit         m_len;
  logic [7:0] m_data;
  logic [3:0] m_ltag;
  bit         m_err;

  data_mem_ctrl #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (256),
    .LD_LAT (LD_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_req   (ld_req),
    .st_req   (st_req),
    .addr     (addr),
    .storData (storData),
    .dst_tag  (dst_tag),
    .loadEn   (loadEn),
    .loadData (loadData),
    .load_tag (load_tag),
    .busy     (busy),
    .req_err  (req_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("loadEn",   32'(loadEn),   32'(m_len));
    chk("loadData", 32'(loadData), 32'(m_data));
    chk("load_tag", 32'(load_tag), 32'(m_tag_out()));
    chk("busy",     32'(busy),     32'(m_pend));
    chk("req_err",  32'(req_err),  32'(m_err));
  endtask

  function automatic logic [3:0] m_tag_out();
    return m_ltag;
  endfunction

  task automatic model_reset();
    m_pend = 1'b0;
    m_len  = 1'b0;
    m_data = 8'h00;
    m_ltag = 4'h0;
    m_err  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, at transaction level.
  task automatic model_edge(input bit ld, input bit st, input logic [7:0] a,
                            input logic [7:0] d, input logic [3:0] t);
    cyc++;
    if (!m_pend) begin
      if (ld && st) m_err = 1'b1;
      else if (st) m_mem[a] = d;
      else if (ld) begin
        m_pend = 1'b1;
        m_due  = cyc + LD_LAT;
        m_addr = a;
        m_tag  = t;
      end
    end else if (ld || st) begin
      m_err = 1'b1;
    end
    m_len = 1'b0;
    if (m_pend && cyc == m_due) begin
      m_len  = 1'b1;
      m_data = m_mem[m_addr];
      m_ltag = m_tag;
      m_pend = 1'b0;
    end
  endtask

  // Driver: present inputs, take one edge, check every output just after it.
  task automatic step(input bit ld, input bit st, input logic [7:0] a,
                      input logic [7:0] d, input logic [3:0] t);
    ld_req   = ld;
    st_req   = st;
    addr     = a;
    storData = d;
    dst_tag  = t;
    @(posedge clk);
    model_edge(ld, st, a, d, t);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
  endtask

  initial begin
    int         r;
    logic [7:0] ra, rd;
    logic [3:0] rt;

    // Reset
    cyc      = 0;
    m_due    = 0;
    m_addr   = 8'h00;
    m_tag    = 4'h0;
    model_reset();
    reset    = 1'b1;
    ld_req   = 1'b0;
    st_req   = 1'b0;
    addr     = 8'h00;
    storData = 8'h00;
    dst_tag  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Give every word a known random value.
    for (int a = 0; a < 256; a++) step(1'b0, 1'b1, 8'(a), 8'($urandom), 4'h0);

    // Store then load after two idle cycles.
    step(1'b0, 1'b1, 8'h10, 8'hA5, 4'h0);
    idle(2);
    step(1'b1, 1'b0, 8'h10, 8'h00, regx);
    idle(LD_LAT + 1);

    // Load on the edge right after a store; then address 0.
    step(1'b0, 1'b1, 8'hFF, 8'h3C, 4'h0);
    step(1'b1, 1'b0, 8'hFF, 8'h00, regc);
    idle(LD_LAT + 1);
    step(1'b0, 1'b1, 8'h00, 8'h11, 4'h0);
    step(1'b1, 1'b0, 8'h00, 8'h00, regd);
    idle(LD_LAT + 1);

    // Back-to-back loads issued as soon as busy drops.
    step(1'b0, 1'b1, 8'h01, 8'h01, 4'h0);
    step(1'b0, 1'b1, 8'h02, 8'h02, 4'h0);
    step(1'b1, 1'b0, 8'h01, 8'h00, regb);
    idle(LD_LAT);
    step(1'b1, 1'b0, 8'h02, 8'h00, regz);
    idle(LD_LAT + 1);

    // Both requests together: error, no write, no load.
    step(1'b1, 1'b1, 8'h20, 8'hFF, rege);
    idle(LD_LAT + 1);
    step(1'b1, 1'b0, 8'h20, 8'h00, regf);
    idle(LD_LAT + 1);

    // Reset between edges while a load is in flight.
    step(1'b1, 1'b0, 8'h30, 8'h00, regy);
    idle(1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;
    idle(LD_LAT + 3);

    // Store while busy is ignored and flagged.
    step(1'b1, 1'b0, 8'h41, 8'h00, regg);
    step(1'b0, 1'b1, 8'h40, 8'h77, 4'h0);
    idle(LD_LAT + 1);
    step(1'b1, 1'b0, 8'h40, 8'h00, regh);
    idle(LD_LAT + 1);

    // Randomized traffic, mostly legal, occasionally violating busy.
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      ra = 8'($urandom);
      rd = 8'($urandom);
      rt = 4'($urandom);
      if (m_pend) begin
        if (r < 10) step(r[0], !r[0], ra, rd, rt);
        else        step(1'b0, 1'b0, ra, rd, rt);
      end else begin
        if (r < 35)      step(1'b1, 1'b0, ra, rd, rt);
        else if (r < 70) step(1'b0, 1'b1, ra, rd, rt);
        else if (r < 73) step(1'b1, 1'b1, ra, rd, rt);
        else             step(1'b0, 1'b0, ra, rd, rt);
      end
    end
    idle(LD_LAT + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
